// File: rtl/composite_pkg.sv
// composite_pkg: shared types and helpers for the composite stream stages.
// Holds the default composite payload struct and the occupancy-width helper.
package composite_pkg;

  localparam int COMPOSITE_DATA_W  = 16;
  localparam int COMPOSITE_DATA2_W = 13;

  // Default-width composite beat used by the fixed-width composite stages.
  typedef struct packed {
    logic        [COMPOSITE_DATA_W-1:0]  data;
    logic signed [COMPOSITE_DATA2_W-1:0] data2;
  } composite_t;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/composite_fifo_if.sv
// composite_fifo_if: producer/consumer handshake bundle for composite_fifo.
// slave = FIFO side, master = the environment driving and draining it.
interface composite_fifo_if
  import composite_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DATA2_W = 13,
  parameter int DEPTH   = 4
) ();

  localparam int CNT_W = count_w(DEPTH);

  logic                      in_valid;
  logic                      in_ready;
  logic        [DATA_W-1:0]  in_data;
  logic signed [DATA2_W-1:0] in_data2;
  logic                      out_valid;
  logic                      out_ready;
  logic        [DATA_W-1:0]  out_data;
  logic signed [DATA2_W-1:0] out_data2;
  logic        [CNT_W-1:0]   count;

  modport slave (
    input  in_valid, in_data, in_data2, out_ready,
    output in_ready, out_valid, out_data, out_data2, count
  );

  modport master (
    output in_valid, in_data, in_data2, out_ready,
    input  in_ready, out_valid, out_data, out_data2, count
  );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers, occupancy counter and push/pop
// qualification for composite_fifo. Pointers wrap naturally at DEPTH.
module fifo_ptr_ctrl
  import composite_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = count_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             out_ready,
  input  logic             bypass_take,
  output logic             in_ready,
  output logic             empty,
  output logic             wr_en,
  output logic             rd_en,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Handshake qualification: a beat taken by the bypass path is never stored.
  always_comb begin
    empty    = (count_q == '0);
    in_ready = rst_n & (count_q != CNT_W'(DEPTH));
    wr_en    = in_valid & in_ready & ~bypass_take;
    rd_en    = ~empty & out_ready;
  end

  // Next-state pointers and occupancy; simultaneous push/pop leaves count as is.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/composite_fifo.sv
// composite_fifo: DEPTH-entry ready/valid FIFO carrying {data, signed data2}.
// Optional zero-latency pass-through on an empty FIFO when the macro
// COMPOSITE_FIFO_BYPASS_EN is defined; the default build has no in->out
// combinational path and a minimum latency of one cycle.
module composite_fifo
  import composite_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int DATA2_W = 13,
  parameter int DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  composite_fifo_if.slave  bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = count_w(DEPTH);
  localparam int ENTRY_W = DATA_W + DATA2_W;

  logic               in_ready;
  logic               empty;
  logic               wr_en;
  logic               rd_en;
  logic               bypass_take;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [ENTRY_W-1:0] wr_word_d;
  logic [ENTRY_W-1:0] head_word;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Pass-through is taken only when empty and the consumer is ready now.
`ifdef COMPOSITE_FIFO_BYPASS_EN
  assign bypass_take = empty & bus.in_valid & bus.out_ready & rst_n;
`else
  assign bypass_take = 1'b0;
`endif

  fifo_ptr_ctrl #(
    .DEPTH (DEPTH)
  ) u_ctrl (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (bus.in_valid),
    .out_ready   (bus.out_ready),
    .bypass_take (bypass_take),
    .in_ready    (in_ready),
    .empty       (empty),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .count       (count)
  );

  // Pack the incoming beat; data2 bits are stored verbatim so the sign survives.
  always_comb begin
    wr_word_d = {bus.in_data, bus.in_data2};
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr] <= wr_word_d;
  end

  assign head_word = mem_q[rd_ptr];

  // Output mux: head entry, or the live input beat when bypassing an empty FIFO.
  always_comb begin
    bus.out_valid = ~empty;
    bus.out_data  = head_word[ENTRY_W-1:DATA2_W];
    bus.out_data2 = head_word[DATA2_W-1:0];
`ifdef COMPOSITE_FIFO_BYPASS_EN
    if (empty && bus.in_valid && rst_n) begin
      bus.out_valid = 1'b1;
      bus.out_data  = bus.in_data;
      bus.out_data2 = bus.in_data2;
    end
`endif
  end

  assign bus.in_ready = in_ready;
  assign bus.count    = count;

endmodule
